// File: rtl/wb_result_select_pkg.sv
// Shared definitions for the writeback result-select stage.
//   LD_* : load size encodings on in_ld_size
//   ERR_*: bit positions within err_flags
//   cnt_e: skid FIFO occupancy state
package wb_pkg;
  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;
  localparam logic [1:0] LD_RSVD = 2'b11;

  localparam int ERR_SEL   = 0;
  localparam int ERR_ALIGN = 1;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_e;
endpackage

// File: rtl/wb_result_select_if.sv
// Bus between execute/memory, the writeback stage and the register bank.
//   slave : stage side (consumes in_*, out_ready; drives in_ready, out_*, err_flags)
//   master: environment side (upstream producer + register bank)
// Optional WB_RESULT_SELECT_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass taps.
interface wb_result_select_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int REG_AW  = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          in_sel;
  logic [NUM_SRC*DATA_W-1:0] in_src_data;
  logic [REG_AW-1:0]         in_rd;
  logic [1:0]                in_ld_size;
  logic                      in_ld_signed;
  logic [1:0]                in_byte_off;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [REG_AW-1:0]         out_rd;
  logic [1:0]                err_flags;
`ifdef WB_RESULT_SELECT_FWD_EN
  logic [1:0]                fwd_valid;
  logic [2*REG_AW-1:0]       fwd_rd;
  logic [2*DATA_W-1:0]       fwd_data;
`endif

  modport slave (
    input  in_valid, in_sel, in_src_data, in_rd, in_ld_size, in_ld_signed, in_byte_off,
    input  out_ready,
    output in_ready, out_valid, out_data, out_rd, err_flags
`ifdef WB_RESULT_SELECT_FWD_EN
    , output fwd_valid, fwd_rd, fwd_data
`endif
  );

  modport master (
    output in_valid, in_sel, in_src_data, in_rd, in_ld_size, in_ld_signed, in_byte_off,
    output out_ready,
    input  in_ready, out_valid, out_data, out_rd, err_flags
`ifdef WB_RESULT_SELECT_FWD_EN
    , input fwd_valid, fwd_rd, fwd_data
`endif
  );
endinterface

// File: rtl/wb_result_select_load_align.sv
// wb_load_align: combinational load data alignment and extension.
//   data_i  : raw 32-bit RAM word
//   size_i  : LD_BYTE / LD_HALF / LD_WORD / LD_RSVD
//   sign_i  : sign-extend byte/half results
//   off_i   : address bits [1:0]
//   data_o  : aligned, extended result
//   err_o   : reserved size or odd half-word offset
module wb_load_align
  import wb_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o,
  output logic        err_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = data_i[8*off_i +: 8];
    // Odd half offsets ignore off[0] and pick by off[1] alone.
    half_v = off_i[1] ? data_i[31:16] : data_i[15:0];
    unique case (size_i)
      LD_BYTE: data_o = {{24{sign_i & byte_v[7]}}, byte_v};
      LD_HALF: data_o = {{16{sign_i & half_v[15]}}, half_v};
      default: data_o = data_i;  // word and reserved
    endcase
    err_o = (size_i == LD_RSVD) | ((size_i == LD_HALF) & off_i[0]);
  end
endmodule

// File: rtl/wb_result_select.sv
// wb_result_select: registered writeback stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : wb_result_select_if.slave (upstream valid/ready with source
//                select and load controls; downstream valid/ready result; err_flags)
// Source 0 is load data and is aligned before enqueue; other sources pass through.
// A 2-entry skid FIFO decouples in_ready from out_ready (in_ready is registered).
// WB_RESULT_SELECT_FWD_EN: exposes both FIFO slots as bypass taps (slot 0 = head).
module wb_result_select
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int REG_AW  = 4
) (
  input logic               clk,
  input logic               rst_n,
  wb_result_select_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
  } ent_t;

  cnt_e              cnt_q, cnt_d;
  ent_t              slot_q [2];
  ent_t              slot_d [2];
  ent_t              new_ent;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] aligned, sel_data;
  logic              align_err, bad_sel, is_ld, push, pop, in_ready, out_valid;

  wb_load_align u_align (
    .data_i (bus.in_src_data[DATA_W-1:0]),
    .size_i (bus.in_ld_size),
    .sign_i (bus.in_ld_signed),
    .off_i  (bus.in_byte_off),
    .data_o (aligned),
    .err_o  (align_err)
  );

  // Source mux; unmatched select falls through to zero data with bad_sel set.
  always_comb begin
    sel_data = '0;
    bad_sel  = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        bad_sel  = 1'b0;
        sel_data = (k == 0) ? aligned : bus.in_src_data[k*DATA_W +: DATA_W];
      end
    end
    is_ld        = (bus.in_sel == '0);
    new_ent.data = sel_data;
    new_ent.rd   = bus.in_rd;
  end

  assign push = bus.in_valid & in_ready;
  assign pop  = out_valid & bus.out_ready;

  // Occupancy FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CNT_EMPTY;
    else        cnt_q <= cnt_d;
  end

  // Occupancy FSM: next state
  always_comb begin
    cnt_d = cnt_q;
    unique case (cnt_q)
      CNT_EMPTY: if (push) cnt_d = CNT_ONE;
      CNT_ONE:   if (push & !pop) cnt_d = CNT_FULL;
                 else if (pop & !push) cnt_d = CNT_EMPTY;
      CNT_FULL:  if (pop) cnt_d = CNT_ONE;
      default:   cnt_d = CNT_EMPTY;
    endcase
  end

  // Occupancy FSM: outputs
  always_comb begin
    in_ready  = (cnt_q != CNT_FULL);
    out_valid = (cnt_q != CNT_EMPTY);
  end

  // Slot 0 is always the head. It is only overwritten by a shift or a push,
  // so after the last pop it keeps the popped value on out_data/out_rd.
  always_comb begin
    slot_d = slot_q;
    if (pop && cnt_q == CNT_FULL) slot_d[0] = slot_q[1];
    if (push) begin
      if (cnt_q == CNT_EMPTY || (cnt_q == CNT_ONE && pop)) slot_d[0] = new_ent;
      else                                                 slot_d[1] = new_ent;
    end
    err_d = err_q;
    if (push) begin
      err_d[ERR_SEL]   = err_q[ERR_SEL]   | bad_sel;
      err_d[ERR_ALIGN] = err_q[ERR_ALIGN] | (is_ld & align_err);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '{default: '0};
      err_q  <= '0;
    end else begin
      slot_q <= slot_d;
      err_q  <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = slot_q[0].data;
  assign bus.out_rd    = slot_q[0].rd;
  assign bus.err_flags = err_q;

`ifdef WB_RESULT_SELECT_FWD_EN
  assign bus.fwd_valid = {cnt_q == CNT_FULL, cnt_q != CNT_EMPTY};
  assign bus.fwd_rd    = {slot_q[1].rd, slot_q[0].rd};
  assign bus.fwd_data  = {slot_q[1].data, slot_q[0].data};
`endif
endmodule

// File: tb/tb_wb_result_select.sv
// Randomized bench for wb_result_select (NUM_SRC=3 so select 3 is out of range).
// A queue-based reference model predicts the FIFO contents, held output and
// sticky flags from the load/select rules; directed cases precede random traffic.
module tb_wb_result_select;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_result_select_if #(.DATA_W(32), .NUM_SRC(3), .SEL_W(2), .REG_AW(4)) w ();
  wb_result_select #(.DATA_W(32), .NUM_SRC(3), .SEL_W(2), .REG_AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [35:0] q[$];       // {data, rd}
  logic [31:0] last_d = '0;
  logic [3:0]  last_rd = '0;
  logic [1:0]  err_m = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  function automatic logic [95:0] mk(input logic [31:0] s0, s1, s2);
    return {s2, s1, s0};
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] sel, input logic [95:0] src,
                                          input logic [1:0] sz, input bit sg, input logic [1:0] off);
    logic [31:0] d, v;
    if (sel >= 3) return 32'h0;
    d = src[sel*32 +: 32];
    if (sel != 0) return d;
    if (sz == 2'b00) begin
      v = (d >> (8 * off)) & 32'hFF;
      if (sg && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (off >= 2) ? (d >> 16) : (d & 32'hFFFF);
      if (sg && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // Check outputs against the model, drive one cycle of inputs, advance model.
  task automatic step(input bit v, input logic [1:0] sel, input logic [95:0] src,
                      input logic [3:0] rd, input logic [1:0] sz, input bit sg,
                      input logic [1:0] off, input bit ordy);
    bit acc;
    @(negedge clk);
    chk("out_valid", w.out_valid, q.size() != 0);
    chk("in_ready", w.in_ready, q.size() < 2);
    if (q.size() != 0) begin
      chk("out_data", w.out_data, q[0][35:4]);
      chk("out_rd", w.out_rd, q[0][3:0]);
    end else begin
      chk("held_data", w.out_data, last_d);
      chk("held_rd", w.out_rd, last_rd);
    end
    chk("err_flags", w.err_flags, err_m);
    w.in_valid = v; w.in_sel = sel; w.in_src_data = src; w.in_rd = rd;
    w.in_ld_size = sz; w.in_ld_signed = sg; w.in_byte_off = off; w.out_ready = ordy;
    acc = v && (q.size() < 2);
    if (ordy && q.size() != 0) begin
      last_d = q[0][35:4];
      last_rd = q[0][3:0];
      void'(q.pop_front());
    end
    if (acc) begin
      q.push_back({ref_res(sel, src, sz, sg, off), rd});
      if (sel >= 3) err_m[0] = 1'b1;
      if (sel == 0 && (sz == 2'b11 || (sz == 2'b01 && off[0]))) err_m[1] = 1'b1;
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 2'd1, '0, 4'd0, 2'b10, 1'b0, 2'd0, ordy);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    w.in_valid = 0; w.in_sel = 0; w.in_src_data = '0; w.in_rd = 0;
    w.in_ld_size = 0; w.in_ld_signed = 0; w.in_byte_off = 0; w.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", w.out_valid, 0);
    chk("rst_in_ready", w.in_ready, 1);
    chk("rst_out_data", w.out_data, 0);
    chk("rst_out_rd", w.out_rd, 0);
    chk("rst_err", w.err_flags, 0);
    rst_n = 1'b1;

    // pass-through source, one-cycle latency
    step(1, 2'd2, mk(32'h0, 32'h0, 32'hDEADBEEF), 4'd5, 2'b10, 0, 2'd0, 1);
    after_edge();
    chk("t1_valid", w.out_valid, 1);
    chk("t1_data", w.out_data, 32'hDEADBEEF);
    chk("t1_ready", w.in_ready, 1);

    // byte loads
    step(1, 2'd0, mk(32'h80F1_7F22, 0, 0), 4'd1, 2'b00, 1, 2'd2, 1);
    after_edge();
    chk("t2_sbyte", w.out_data, 32'hFFFF_FFF1);
    step(1, 2'd0, mk(32'h80F1_7F22, 0, 0), 4'd2, 2'b00, 0, 2'd1, 1);
    after_edge();
    chk("t2_ubyte", w.out_data, 32'h0000_007F);

    // misaligned signed half
    step(1, 2'd0, mk(32'h8001_0000, 0, 0), 4'd3, 2'b01, 1, 2'd3, 1);
    after_edge();
    chk("t3_half", w.out_data, 32'hFFFF_8001);
    chk("t3_err", w.err_flags, 2'b10);
    idle(1);
    idle(1);
    after_edge();
    chk("t3_err_sticky", w.err_flags, 2'b10);

    // backpressure: A, B fill, C held off, then drain in order
    step(1, 2'd1, mk(0, 32'hA, 0), 4'd10, 2'b10, 0, 2'd0, 0);
    step(1, 2'd1, mk(0, 32'hB, 0), 4'd11, 2'b10, 0, 2'd0, 0);
    after_edge();
    chk("t4_full", w.in_ready, 0);
    step(1, 2'd1, mk(0, 32'hC, 0), 4'd12, 2'b10, 0, 2'd0, 0);
    step(1, 2'd1, mk(0, 32'hC, 0), 4'd12, 2'b10, 0, 2'd0, 1);
    step(1, 2'd1, mk(0, 32'hC, 0), 4'd12, 2'b10, 0, 2'd0, 1);
    repeat (4) idle(1);

    // out-of-range select
    step(1, 2'd3, mk(32'h1, 32'h2, 32'h3), 4'd9, 2'b10, 0, 2'd0, 1);
    after_edge();
    chk("t5_data", w.out_data, 0);
    chk("t5_rd", w.out_rd, 9);
    chk("t5_err_sel", w.err_flags[0], 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           {32'($urandom), 32'($urandom), 32'($urandom)}, 4'($urandom),
           2'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 2) != 0);
    end
    repeat (3) idle(1);

    // reset while full
    step(1, 2'd2, mk(0, 0, 32'h1111), 4'd1, 2'b10, 0, 2'd0, 0);
    step(1, 2'd2, mk(0, 0, 32'h2222), 4'd2, 2'b10, 0, 2'd0, 0);
    idle(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", w.out_valid, 0);
    chk("t6_ready", w.in_ready, 1);
    chk("t6_err", w.err_flags, 0);
    chk("t6_data", w.out_data, 0);
    q.delete();
    last_d = '0; last_rd = '0; err_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 2'd1, mk(0, 32'h5A5A, 0), 4'd7, 2'b10, 0, 2'd0, 1);
    repeat (2) idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
